// File: rtl/scene_sequencer_if.sv
// rtl/scene_sequencer_if.sv - tick/skip controls, colour in and scaled colour/status out
interface scene_sequencer_if;
  logic       frame_tick;
  logic       pause_n;
  logic       skip;
  logic [5:0] r_in;
  logic [5:0] g_in;
  logic [5:0] b_in;
  logic [1:0] scene;
  logic [5:0] fade;
  logic       scene_start;
  logic [5:0] r_o;
  logic [5:0] g_o;
  logic [5:0] b_o;

  modport master (
    output frame_tick, pause_n, skip, r_in, g_in, b_in,
    input  scene, fade, scene_start, r_o, g_o, b_o
  );

  modport slave (
    input  frame_tick, pause_n, skip, r_in, g_in, b_in,
    output scene, fade, scene_start, r_o, g_o, b_o
  );
endinterface

// File: rtl/scene_sequencer.sv
// rtl/scene_sequencer.sv - demo scene fade-in/hold/fade-out sequencer with colour scaling
module scene_sequencer #(
  parameter int NUM_SCENES  = 3,
  parameter int HOLD_FRAMES = 600,
  parameter int FADE_RATE   = 4
) (
  input  logic               clk48,
  input  logic               rst_n,
  scene_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, FADE_IN, HOLD, FADE_OUT} state_t;

  localparam logic [6:0]  RATE       = 7'(FADE_RATE);
  localparam logic [10:0] HOLD_LAST  = 11'(HOLD_FRAMES - 1);
  localparam logic [1:0]  SCENE_LAST = 2'(NUM_SCENES - 1);

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_fade, w_fade_nxt;
  logic [1:0]  r_scene, w_scene_nxt;
  logic [10:0] r_hold, w_hold_nxt;
  logic        r_skip_pend, w_skip_nxt;
  logic        r_scene_start, w_start_nxt;
  logic [5:0]  r_r_o, r_g_o, r_b_o;

  logic        w_active;
  logic        w_skip_req;
  logic [6:0]  w_fade_ext;
  logic [6:0]  w_fade_up;
  logic [6:0]  w_gain;

  assign w_active   = bus.frame_tick & bus.pause_n;
  assign w_skip_req = r_skip_pend | bus.skip;
  assign w_fade_ext = {1'b0, r_fade};
  assign w_fade_up  = w_fade_ext + RATE;
  // Full brightness uses a gain of 64 so the >>6 scaling passes colour through exactly.
  assign w_gain     = (r_fade == 6'd63) ? 7'd64 : w_fade_ext;

  always_comb begin
    w_state_nxt = r_state;
    w_fade_nxt  = r_fade;
    w_scene_nxt = r_scene;
    w_hold_nxt  = r_hold;
    w_skip_nxt  = w_skip_req;
    w_start_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_skip_nxt = 1'b0;
        if (w_active) begin
          w_state_nxt = FADE_IN;
          w_scene_nxt = 2'd0;
          w_fade_nxt  = 6'd0;
          w_start_nxt = 1'b1;
        end
      end
      FADE_IN: begin
        if (w_active && w_skip_req) begin
          w_state_nxt = FADE_OUT;
          w_skip_nxt  = 1'b0;
        end else if (w_active) begin
          if (w_fade_up >= 7'd63) begin
            w_fade_nxt  = 6'd63;
            w_hold_nxt  = 11'd0;
            w_state_nxt = HOLD;
          end else begin
            w_fade_nxt = w_fade_up[5:0];
          end
        end
      end
      HOLD: begin
        if (w_active && (w_skip_req || r_hold == HOLD_LAST)) begin
          w_state_nxt = FADE_OUT;
          w_skip_nxt  = 1'b0;
        end else if (w_active) begin
          w_hold_nxt = r_hold + 11'd1;
        end
      end
      FADE_OUT: begin
        w_skip_nxt = 1'b0;
        if (w_active) begin
          if (w_fade_ext <= RATE) begin
            w_fade_nxt  = 6'd0;
            w_scene_nxt = (r_scene == SCENE_LAST) ? 2'd0 : r_scene + 2'd1;
            w_state_nxt = FADE_IN;
            w_start_nxt = 1'b1;
          end else begin
            w_fade_nxt = 6'(w_fade_ext - RATE);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_fade        <= 6'd0;
      r_scene       <= 2'd0;
      r_hold        <= 11'd0;
      r_skip_pend   <= 1'b0;
      r_scene_start <= 1'b0;
      r_r_o         <= 6'd0;
      r_g_o         <= 6'd0;
      r_b_o         <= 6'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_fade        <= w_fade_nxt;
      r_scene       <= w_scene_nxt;
      r_hold        <= w_hold_nxt;
      r_skip_pend   <= w_skip_nxt;
      r_scene_start <= w_start_nxt;
      r_r_o         <= 6'((12'(bus.r_in) * 12'(w_gain)) >> 6);
      r_g_o         <= 6'((12'(bus.g_in) * 12'(w_gain)) >> 6);
      r_b_o         <= 6'((12'(bus.b_in) * 12'(w_gain)) >> 6);
    end
  end

  assign bus.scene       = r_scene;
  assign bus.fade        = r_fade;
  assign bus.scene_start = r_scene_start;
  assign bus.r_o         = r_r_o;
  assign bus.g_o         = r_g_o;
  assign bus.b_o         = r_b_o;
endmodule

// File: tb/tb_scene_sequencer.sv
// tb/tb_scene_sequencer.sv - directed table, corner sequences and randomized model check
module tb_scene_sequencer;
  localparam int NS = 3;
  localparam int HF = 3;
  localparam int FR = 4;
  localparam int P_IDLE = 0, P_IN = 1, P_HOLD = 2, P_OUT = 3;

  logic clk48 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk48 = ~clk48;

  scene_sequencer_if bus ();

  scene_sequencer #(.NUM_SCENES(NS), .HOLD_FRAMES(HF), .FADE_RATE(FR)) dut (
    .clk48(clk48),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  int m_phase, m_fade, m_scene, m_hold, m_r, m_g, m_b;
  bit m_skp, m_start, prev_start;

  typedef struct {
    int ticks;
    bit pause;
    bit skip_first;
    int exp_fade;
    int exp_scene;
    bit exp_start;
  } vec_t;
  vec_t tbl[18];

  function automatic vec_t mk(int t, bit p, bit s, int f, int sc, bit st);
    vec_t v;
    v.ticks = t; v.pause = p; v.skip_first = s;
    v.exp_fade = f; v.exp_scene = sc; v.exp_start = st;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int scale(int x, int f);
    return (x * ((f == 63) ? 64 : f)) / 64;
  endfunction

  task automatic model(bit rst, bit tick, bit pause, bit sk, int r, int g, int b);
    bit act, req;
    if (!rst) begin
      m_phase = P_IDLE; m_fade = 0; m_scene = 0; m_hold = 0; m_skp = 0;
      m_start = 0; m_r = 0; m_g = 0; m_b = 0;
    end else begin
      m_r = scale(r, m_fade); m_g = scale(g, m_fade); m_b = scale(b, m_fade);
      m_start = 0;
      act = tick && pause;
      req = m_skp || sk;
      case (m_phase)
        P_IDLE: begin
          m_skp = 0;
          if (act) begin m_phase = P_IN; m_scene = 0; m_fade = 0; m_start = 1; end
        end
        P_IN, P_HOLD: begin
          if (act && req) begin
            m_phase = P_OUT; m_skp = 0;
          end else begin
            m_skp = req;
            if (act && m_phase == P_IN) begin
              if (m_fade + FR >= 63) begin m_fade = 63; m_hold = 0; m_phase = P_HOLD; end
              else m_fade = m_fade + FR;
            end else if (act) begin
              if (m_hold == HF - 1) m_phase = P_OUT;
              else m_hold = m_hold + 1;
            end
          end
        end
        default: begin
          m_skp = 0;
          if (act) begin
            if (m_fade <= FR) begin
              m_fade = 0; m_scene = (m_scene + 1) % NS; m_phase = P_IN; m_start = 1;
            end else m_fade = m_fade - FR;
          end
        end
      endcase
    end
  endtask

  task automatic cyc(bit rst, bit tick, bit pause, bit sk, logic [5:0] r, logic [5:0] g, logic [5:0] b);
    @(negedge clk48);
    rst_n = rst; bus.frame_tick = tick; bus.pause_n = pause; bus.skip = sk;
    bus.r_in = r; bus.g_in = g; bus.b_in = b;
    @(posedge clk48);
    model(rst, tick, pause, sk, int'(r), int'(g), int'(b));
    #1;
    chk("fade", int'(bus.fade), m_fade);
    chk("scene", int'(bus.scene), m_scene);
    chk("scene_start", int'(bus.scene_start), int'(m_start));
    chk("r_o", int'(bus.r_o), m_r);
    chk("g_o", int'(bus.g_o), m_g);
    chk("b_o", int'(bus.b_o), m_b);
    chk("start_twice", int'(prev_start && bus.scene_start), 0);
    prev_start = bus.scene_start;
  endtask

  task automatic rcyc(bit rst, bit tick, bit pause, bit sk);
    cyc(rst, tick, pause, sk, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
        6'($urandom_range(0, 63)));
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      rcyc(1, 1, 1, 0);
      rcyc(1, 0, 1, 0);
    end
  endtask

  initial begin
    bus.frame_tick = 0; bus.pause_n = 1; bus.skip = 0;
    bus.r_in = 0; bus.g_in = 0; bus.b_in = 0;
    prev_start = 0;

    tbl[0]  = mk(1,  1, 0, 0,  0, 1);
    tbl[1]  = mk(4,  1, 0, 16, 0, 0);
    tbl[2]  = mk(1,  1, 0, 20, 0, 0);
    tbl[3]  = mk(10, 0, 0, 20, 0, 0);
    tbl[4]  = mk(1,  1, 0, 24, 0, 0);
    tbl[5]  = mk(9,  1, 0, 60, 0, 0);
    tbl[6]  = mk(1,  1, 0, 63, 0, 0);
    tbl[7]  = mk(3,  1, 0, 63, 0, 0);
    tbl[8]  = mk(1,  1, 0, 59, 0, 0);
    tbl[9]  = mk(14, 1, 0, 3,  0, 0);
    tbl[10] = mk(1,  1, 1, 0,  1, 1);
    tbl[11] = mk(1,  1, 0, 4,  1, 0);
    tbl[12] = mk(15, 1, 0, 63, 1, 0);
    tbl[13] = mk(1,  1, 0, 63, 1, 0);
    tbl[14] = mk(1,  1, 1, 63, 1, 0);
    tbl[15] = mk(1,  1, 0, 59, 1, 0);
    tbl[16] = mk(15, 1, 0, 0,  2, 1);
    tbl[17] = mk(35, 1, 0, 0,  0, 1);

    rcyc(0, 0, 1, 0);
    rcyc(0, 1, 1, 1);
    chk("reset_fade", int'(bus.fade), 0);
    chk("reset_scene", int'(bus.scene), 0);
    chk("reset_r_o", int'(bus.r_o), 0);

    for (int k = 0; k < 18; k++) begin
      if (tbl[k].skip_first) rcyc(1, 0, 1, 1);
      for (int i = 0; i < tbl[k].ticks; i++) begin
        rcyc(1, 1, tbl[k].pause, 0);
        if (i == tbl[k].ticks - 1) begin
          chk($sformatf("row%0d_fade", k), int'(bus.fade), tbl[k].exp_fade);
          chk($sformatf("row%0d_scene", k), int'(bus.scene), tbl[k].exp_scene);
          chk($sformatf("row%0d_start", k), int'(bus.scene_start), int'(tbl[k].exp_start));
        end
        rcyc(1, 0, 1, 0);
      end
    end

    rcyc(0, 0, 1, 0);
    ticks(1);
    cyc(1, 0, 1, 0, 6'd40, 6'd40, 6'd40);
    chk("scale_fade0", int'(bus.r_o), 0);
    ticks(8);
    cyc(1, 0, 1, 0, 6'd63, 6'd63, 6'd63);
    chk("scale_fade32", int'(bus.r_o), 31);
    ticks(8);
    cyc(1, 0, 1, 0, 6'd63, 6'd1, 6'd0);
    chk("scale_fade63_r", int'(bus.r_o), 63);
    chk("scale_fade63_g", int'(bus.g_o), 1);

    ticks(3 + 16 + 35 + 19 + 6);
    chk("pre_reset_fade", int'(bus.fade), 39);
    chk("pre_reset_scene", int'(bus.scene), 2);
    cyc(0, 1, 1, 1, 6'd63, 6'd63, 6'd63);
    chk("mid_reset_fade", int'(bus.fade), 0);
    chk("mid_reset_scene", int'(bus.scene), 0);
    chk("mid_reset_r_o", int'(bus.r_o), 0);
    rcyc(0, 1, 1, 0);
    rcyc(1, 1, 1, 0);
    chk("post_reset_start", int'(bus.scene_start), 1);
    chk("post_reset_fade", int'(bus.fade), 0);
    rcyc(1, 0, 1, 0);
    rcyc(1, 1, 1, 0);
    chk("post_reset_fade2", int'(bus.fade), 4);

    for (int i = 0; i < 4000; i++) begin
      rcyc($urandom_range(0, 199) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
